data_write_buffer: RTL and testbench

DATA_WRITE_BUFFER -- requirements
Module: data_write_buffer

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/data_write_buffer.sv | 163 ++++++++++++++++
 tb/tb_data_write_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the posted-write buffer: entry layout, downstream FSM
// state encoding and the default buffer depth.
package wb_pkg;

  localparam int unsigned WB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } wb_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREQ  = 3'd1,
    ST_WRESP = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RRESP = 3'd4
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Posted-write FIFO: entry storage, head/tail pointers, occupancy count,
// full/empty flags and a per-entry word-address match vector used for
// read-after-write hazard detection.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH_DEFAULT,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  input  logic [29:0]      cmp_word,
  output wb_entry_t        head_entry,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] match_vec
);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state for storage, pointers (wrap naturally at power-of-two depth) and count
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);

  // Slot i is live when its distance from head is below the occupancy
  always_comb begin
    match_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(i) - head_q} < count_q) && (mem_q[i].addr[31:2] == cmp_word)) begin
        match_vec[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_write_buffer.sv
// Posted write buffer between the D-cache (sram-like upstream) and the AXI
// bridge (sram-like downstream). Writes are acknowledged one cycle after
// acceptance and drained in order; reads are forwarded one at a time.
// Optional feature macro: WB_BYPASS_EN lets reads overtake buffered writes
// whose word address does not conflict with the read.
module data_write_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_state_t   state_q, state_d;
  logic        wr_ack_q, wr_ack_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [1:0]  rd_size_q, rd_size_d;

  wb_entry_t        push_entry, head_entry;
  logic [CW-1:0]    count;
  logic             full, empty, push, pop;
  logic [DEPTH-1:0] match_vec;
  logic             wr_accept, rd_accept, rd_gate, rd_done;

  assign push_entry = '{addr: cpu_addr, size: cpu_size, wdata: cpu_wdata};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .cmp_word   (cpu_addr[31:2]),
    .head_entry (head_entry),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .match_vec  (match_vec)
  );

`ifdef WB_BYPASS_EN
  logic [29:0] fly_word_q, fly_word_d;
  logic [CW-1:0] unused_count;
  assign unused_count = count;

  // Word address of the write that has left the FIFO and awaits mem_data_ok
  always_comb begin
    fly_word_d = fly_word_q;
    if (pop) fly_word_d = head_entry.addr[31:2];
  end

  // In-flight write word register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fly_word_q <= '0;
    else      fly_word_q <= fly_word_d;
  end

  // The WREQ word is still the live head entry, so match_vec covers it
  assign rd_gate = ~(|match_vec) &
                   ~((state_q == ST_WRESP) && (fly_word_q == cpu_addr[31:2]));
`else
  logic [DEPTH-1:0] unused_match;
  assign unused_match = match_vec;
  assign rd_gate = (count == '0) && (state_q != ST_WREQ) && (state_q != ST_WRESP);
`endif

  assign wr_accept   = rst & cpu_req & cpu_wr & ~full & ~rd_valid_q;
  assign rd_accept   = rst & cpu_req & ~cpu_wr & ~rd_valid_q & ~wr_ack_q & rd_gate;
  assign cpu_addr_ok = wr_accept | rd_accept;
  assign push        = wr_accept;
  assign pop         = (state_q == ST_WREQ) && mem_addr_ok;
  assign rd_done     = (state_q == ST_RRESP) && mem_data_ok;
  assign cpu_data_ok = wr_ack_q | rd_done;
  assign cpu_rdata   = rd_done ? mem_rdata : '0;

  // Downstream FSM next state and upstream read/ack bookkeeping
  always_comb begin
    state_d    = state_q;
    wr_ack_d   = wr_accept;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    rd_size_d  = rd_size_q;
    if (rd_accept) begin
      rd_valid_d = 1'b1;
      rd_addr_d  = cpu_addr;
      rd_size_d  = cpu_size;
    end
    if (rd_done) rd_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_valid_q)  state_d = ST_RREQ;
        else if (!empty) state_d = ST_WREQ;
      end
      ST_WREQ:  if (mem_addr_ok) state_d = ST_WRESP;
      ST_WRESP: if (mem_data_ok) state_d = ST_IDLE;
      ST_RREQ:  if (mem_addr_ok) state_d = ST_RRESP;
      ST_RRESP: if (mem_data_ok) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_size_q  <= rd_size_d;
    end
  end

  // Downstream request decode; sources are registers, so they hold while stalled
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_WREQ: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_size  = head_entry.size;
        mem_addr  = head_entry.addr;
        mem_wdata = head_entry.wdata;
      end
      ST_RREQ: begin
        mem_req  = 1'b1;
        mem_size = rd_size_q;
        mem_addr = rd_addr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_write_buffer.sv
// Self-checking bench for data_write_buffer (DEPTH=4).
module tb_data_write_buffer;

  logic        clk, rst;
  logic        cpu_req, cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_addr_ok, cpu_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  data_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int unsigned lat;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } wexp_t;

  int unsigned n_vec = 0, n_err = 0;
  int unsigned cyc = 0;
  wexp_t       wq[$];
  logic [31:0] exp_rd_addr;
  logic [1:0]  exp_rd_size;
  bit          addr_ok_en = 0;
  int unsigned lat = 1;
  int unsigned resp_cnt = 0;
  logic [31:0] resp_addr;
  bit          resp_rd;
  bit          rd_seen = 0;
  int unsigned rd_req_cyc = 0, last_wdok_cyc = 0, rd_acc_cyc = 0;
  logic [31:0] watch_addr = 32'hFFFF_FFFF;
  int unsigned watch_hs_cyc = 0, watch_dok_cyc = 0;
  bit          cnt_chk_en = 0;
  int          exp_cnt = 0;
  int unsigned sim_cnt = 0;

  function automatic logic [31:0] rmodel(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Downstream slave model and scoreboard checker
  initial begin
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_data_ok = 0;
      mem_rdata   = 32'hBAD0_BAD0;
      if (!rst) resp_cnt = 0;
      else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_data_ok = 1;
          if (resp_rd) mem_rdata = rmodel(resp_addr);
          else begin
            last_wdok_cyc = cyc;
            if (resp_addr == watch_addr) watch_dok_cyc = cyc;
          end
        end
      end
      mem_addr_ok = addr_ok_en;
      #2;
      if (rst) begin
        if (cnt_chk_en) begin
          chk("fifo_count", 32'(dut.u_fifo.count_q), 32'(exp_cnt));
          if ((cpu_req & cpu_wr & cpu_addr_ok) && (mem_req & mem_wr & mem_addr_ok)) sim_cnt++;
          exp_cnt = exp_cnt + int'(cpu_req & cpu_wr & cpu_addr_ok) - int'(mem_req & mem_wr & mem_addr_ok);
        end
        if (mem_req && !mem_wr && !rd_seen) begin
          rd_seen = 1;
          rd_req_cyc = cyc;
        end
        if (mem_req && mem_addr_ok) begin
          resp_cnt  = lat;
          resp_addr = mem_addr;
          resp_rd   = !mem_wr;
          if (mem_wr) begin
            if (mem_addr == watch_addr) watch_hs_cyc = cyc;
            if (wq.size() == 0) chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            else begin
              wexp_t e;
              e = wq.pop_front();
              chk("wr_mem_addr", mem_addr, e.addr);
              chk("wr_mem_size", 32'(mem_size), 32'(e.size));
              chk("wr_mem_wdata", mem_wdata, e.wdata);
            end
          end else begin
            chk("rd_mem_addr", mem_addr, exp_rd_addr);
            chk("rd_mem_size", 32'(mem_size), 32'(exp_rd_size));
          end
        end
      end
    end
  end

  task automatic cpu_xact(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          output int unsigned wcyc);
    bit acc = 0;
    bit got = 0;
    int unsigned g = 0;
    wcyc = 0;
    @(negedge clk);
    cpu_req = 1; cpu_wr = wr; cpu_addr = addr; cpu_size = size; cpu_wdata = wdata;
    while (!acc && wcyc < 300) begin
      #1;
      if (cpu_addr_ok) begin
        acc = 1;
        if (wr) wq.push_back('{addr, size, wdata});
        else begin
          exp_rd_addr = addr; exp_rd_size = size; rd_acc_cyc = cyc;
        end
      end else begin
        @(negedge clk);
        wcyc++;
      end
    end
    chk("addr_ok_seen", 32'(acc), 1);
    @(negedge clk);
    cpu_req = 0;
    if (acc && wr) begin
      #1;
      chk("wr_data_ok", 32'(cpu_data_ok), 1);
    end else if (acc) begin
      while (!got && g < 300) begin
        #1;
        if (cpu_data_ok) begin
          got = 1;
          chk("rd_data", cpu_rdata, exp_rdata);
        end else begin
          @(negedge clk);
          g++;
        end
      end
      chk("rd_data_ok_seen", 32'(got), 1);
    end
  endtask

  task automatic burst_writes(input int unsigned n, input logic [31:0] base, input logic [31:0] dbase);
    int unsigned i = 0, guard = 0;
    bit prev_acc = 0;
    @(negedge clk);
    while (i < n && guard < 300) begin
      cpu_req = 1; cpu_wr = 1; cpu_size = 2'd2;
      cpu_addr = base + 32'(i * 4); cpu_wdata = dbase + 32'(i);
      #1;
      if (prev_acc) chk("burst_data_ok", 32'(cpu_data_ok), 1);
      prev_acc = cpu_addr_ok;
      if (cpu_addr_ok) begin
        wq.push_back('{cpu_addr, cpu_size, cpu_wdata});
        i++;
      end
      guard++;
      @(negedge clk);
    end
    cpu_req = 0;
    #1;
    if (prev_acc) chk("burst_data_ok", 32'(cpu_data_ok), 1);
    chk("burst_count", i, n);
  endtask

  task automatic wait_idle();
    int unsigned g = 0;
    while (!(wq.size() == 0 && resp_cnt == 0 && !mem_req) && g < 400) begin
      @(negedge clk); #3;
      g++;
    end
    chk("idle_reached", 32'(g < 400), 1);
    repeat (2) @(negedge clk);
  endtask

  vec_t        tbl[6];
  int unsigned wc;
  int unsigned stale;

  initial begin
    tbl[0] = '{1, 32'h0000_0100, 2'd2, 32'h1111_2222, 32'h0, 1};
    tbl[1] = '{1, 32'h0000_0104, 2'd1, 32'h3333_4444, 32'h0, 2};
    tbl[2] = '{0, 32'h0000_0200, 2'd2, 32'h0, rmodel(32'h0000_0200), 1};
    tbl[3] = '{1, 32'h0000_0108, 2'd0, 32'h0000_0055, 32'h0, 3};
    tbl[4] = '{0, 32'h0000_0104, 2'd2, 32'h0, rmodel(32'h0000_0104), 2};
    tbl[5] = '{0, 32'h0000_03FC, 2'd2, 32'h0, rmodel(32'h0000_03FC), 1};

    rst = 0; cpu_req = 1; cpu_wr = 1; cpu_size = 2'd2; cpu_addr = 32'h1234; cpu_wdata = 32'h5678;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cpu_addr_ok", 32'(cpu_addr_ok), 0);
    chk("rst_cpu_data_ok", 32'(cpu_data_ok), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_count", 32'(dut.u_fifo.count_q), 0);
    cpu_req = 0;
    @(negedge clk);
    rst = 1;

    // Table-driven mixed traffic
    addr_ok_en = 1;
    for (int k = 0; k < 6; k++) begin
      lat = tbl[k].lat;
      cpu_xact(tbl[k].wr, tbl[k].addr, tbl[k].size, tbl[k].wdata, tbl[k].exp_rdata, wc);
    end
    wait_idle();

    // Posted write timing
    lat = 3;
    cpu_xact(1, 32'h0000_1000, 2'd2, 32'hDEAD_BEEF, 32'h0, wc);
    chk("posted_accept_wait", wc, 0);
    chk("posted_no_req_yet", 32'(mem_req), 0);
    @(negedge clk); #1;
    chk("posted_mem_req", 32'(mem_req), 1);
    chk("posted_mem_wr", 32'(mem_wr), 1);
    chk("posted_mem_addr", mem_addr, 32'h0000_1000);
    chk("posted_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    wait_idle();

    // Full stall: the 5th write waits until the first dequeue, then is accepted
    addr_ok_en = 0; lat = 2;
    for (int k = 0; k < 4; k++) cpu_xact(1, 32'h4000 + 32'(k * 4), 2'd2, 32'hF000_0000 + 32'(k), 32'h0, wc);
    @(negedge clk);
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h4010; cpu_size = 2'd2; cpu_wdata = 32'hF000_0004;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("full_stall", 32'(cpu_addr_ok), 0);
      chk("hold_mem_req", 32'(mem_req), 1);
      chk("hold_mem_addr", mem_addr, 32'h4000);
      if (s == 2) addr_ok_en = 1;
      @(negedge clk);
    end
    #1;
    chk("full_deq_cycle", 32'(cpu_addr_ok), 0);
    @(negedge clk); #1;
    chk("full_accept", 32'(cpu_addr_ok), 1);
    if (cpu_addr_ok) wq.push_back('{32'h4010, 2'd2, 32'hF000_0004});
    @(negedge clk);
    cpu_req = 0; #1;
    chk("full_data_ok", 32'(cpu_data_ok), 1);
    wait_idle();

`ifdef WB_BYPASS_EN
    // Bypass: a non-conflicting read overtakes a buffered write; a conflicting one waits
    lat = 4; watch_addr = 32'h2004; rd_seen = 0;
    burst_writes(2, 32'h2000, 32'hB000_0000);
    cpu_xact(0, 32'h3000, 2'd2, 32'h0, rmodel(32'h3000), wc);
    chk("bypass_read_first", 32'(rd_req_cyc < watch_hs_cyc), 1);
    cpu_xact(0, 32'h2004, 2'd2, 32'h0, rmodel(32'h2004), wc);
    chk("bypass_conflict_wait", 32'(rd_acc_cyc > watch_dok_cyc), 1);
    wait_idle();
`else
    // Ordering: read is issued only after the earlier write's mem_data_ok
    lat = 3; rd_seen = 0;
    cpu_xact(1, 32'h2000, 2'd2, 32'hC0FF_EE00, 32'h0, wc);
    cpu_xact(0, 32'h3000, 2'd2, 32'h0, rmodel(32'h3000), wc);
    chk("read_after_write", 32'(rd_req_cyc > last_wdok_cyc), 1);
    wait_idle();
`endif

    // Pointer wrap with simultaneous enqueue/dequeue
    lat = 1; exp_cnt = 0; sim_cnt = 0; cnt_chk_en = 1;
    burst_writes(10, 32'h5000, 32'hA000_0000);
    wait_idle();
    cnt_chk_en = 0;
    chk("simul_enq_deq_seen", 32'(sim_cnt > 0), 1);

    // Reset in WRESP with 3 entries buffered
    lat = 50;
    burst_writes(4, 32'h6000, 32'h6600_0000);
    repeat (2) @(negedge clk);
    #1;
    chk("pre_reset_count", 32'(dut.u_fifo.count_q), 3);
    @(negedge clk);
    rst = 0; cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h7000;
    #1;
    chk("mrst_mem_req", 32'(mem_req), 0);
    chk("mrst_mem_wr", 32'(mem_wr), 0);
    chk("mrst_mem_size", 32'(mem_size), 0);
    chk("mrst_mem_addr", mem_addr, 0);
    chk("mrst_mem_wdata", mem_wdata, 0);
    chk("mrst_cpu_addr_ok", 32'(cpu_addr_ok), 0);
    chk("mrst_cpu_data_ok", 32'(cpu_data_ok), 0);
    chk("mrst_cpu_rdata", cpu_rdata, 0);
    chk("mrst_count", 32'(dut.u_fifo.count_q), 0);
    wq.delete();
    repeat (2) @(negedge clk);
    cpu_req = 0; rst = 1;
    stale = 0;
    repeat (15) begin
      @(negedge clk); #1;
      if (mem_req || cpu_data_ok) stale++;
    end
    chk("no_stale_after_reset", stale, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
